i2c_codec_target: RTL and testbench
===================================

I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 The block SHALL take parameter DEV_ADDR, default 7'h1A, as the 7-bit I2C target address (write byte 8'h34).
REQ-002 The block SHALL take parameter NUM_REGS, default 16, as the number of implemented 9-bit registers, indexed 0..NUM_REGS-1.
REQ-003 iCLK  input  1  system clock; SHALL be at least 16x the SCL frequency.
REQ-004 iRST_N  input  1  asynchronous, active-low reset.
REQ-005 iI2C_SCLK  input  1  I2C clock from the bus master.
REQ-006 ioI2C_SDAT  inout  1  I2C data line; the block SHALL only drive 1'b0 or 1'bz (open-drain).
REQ-007 iRD_ADDR  input  4  register read-port index.
REQ-008 oRD_DATA  output  9  registered contents of register iRD_ADDR.
REQ-009 oWR_STROBE  output  1  single-cycle pulse on each committed register write.
REQ-010 oWR_ADDR  output  7  register address of the last committed write.
REQ-011 oWR_DATA  output  9  data of the last committed write.
REQ-012 oBUSY  output  1  high from a START until the following STOP.

Function
REQ-013 SCL and SDA SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized values.
- Total input latency: 3 iCLK.
REQ-014 START SHALL be detected as synchronized SDA 1->0 while SCL is high; STOP as SDA 0->1 while SCL is high.
REQ-015 Data bits SHALL be sampled MSB first on the synchronized SCL rising edge.
REQ-016 FSM states: IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, IGNORE.
REQ-017 Transitions:
- START from any state -> DEV, with the bit counter cleared.
- STOP from any state -> IDLE.
REQ-018 DEV SHALL shift 8 bits, then:
- byte == {DEV_ADDR,1'b0} -> ACK_DEV.
- otherwise -> IGNORE, with no ACK driven. This includes R/W=1.
REQ-019 REG SHALL shift 8 bits {reg_addr[6:0], data[8]}, then go to ACK_REG.
REQ-020 DATA SHALL shift 8 bits data[7:0], then go to ACK_DATA.
REQ-021 In an ACK state the block SHALL hold SDA low:
- from the first SCL falling edge after the 8th bit
- until the next SCL falling edge
- then advance ACK_DEV->REG, ACK_REG->DATA, ACK_DATA->IGNORE.
REQ-022 IGNORE SHALL never drive SDA; further bytes in the same transaction SHALL be NACKed.
REQ-023 Write commit SHALL occur in the iCLK cycle where the 8th DATA bit is sampled:
- if reg_addr < NUM_REGS: the register is updated, oWR_STROBE=1 for that cycle, and oWR_ADDR/oWR_DATA are loaded.
- if reg_addr >= NUM_REGS: the byte is still ACKed, with no strobe and no register change.
REQ-024 A STOP or START arriving before the DATA byte completes SHALL abort the transaction with no register write.
REQ-025 oRD_DATA SHALL equal regs[iRD_ADDR] one iCLK after iRD_ADDR is applied.
- Out-of-range index returns 9'h000.
REQ-026 A commit and a read of the same index in the same cycle SHALL return the new value on the following cycle.
REQ-027 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.

Reset
REQ-028 While iRST_N is low:
- FSM=IDLE, counter=0, all registers=9'h000.
- oRD_DATA=0, oWR_STROBE=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0.
- SDA released (z) immediately, without waiting for iCLK.
REQ-029 After reset is released mid-transaction, the block SHALL stay in IDLE until a new START; no partial write is committed.

Verification
REQ-030 Bytes 34 12 01 + STOP -> three ACKs; oWR_STROBE once; oWR_ADDR=7'h09, oWR_DATA=9'h001; iRD_ADDR=9 reads 9'h001.
REQ-031 Bytes 34 08 D2 -> R4=9'h0D2; then 34 09 D2 -> R4=9'h1D2 (data[8] taken from the REG byte).
REQ-032 Bytes 36 12 01 -> no ACK on any byte, SDA never driven, no strobe, all registers unchanged.
REQ-033 Bytes 34 12, then STOP -> no strobe; then repeated START + 34 0E 02 -> R7=9'h002 with exactly one strobe.
REQ-034 iRST_N asserted during ACK_REG while SDA is held low -> SDA released immediately; registers read 0; the next valid write commits normally.
REQ-035 Bytes 34 20 55 (reg 16, out of range) -> all bytes ACKed, no strobe; an extra 4th byte is NACKed.

Source files
------------

// File: rtl/i2c_codec_target.sv
// i2c_codec_target
//   Write-only I2C target holding NUM_REGS 9-bit registers, as used by
//   WM8731-style codecs. A write is START, 8'h34 (DEV_ADDR + W),
//   {reg_addr[6:0], data[8]}, data[7:0], STOP. Each byte is ACKed by
//   holding SDA low for one SCL low-high-low window.
// Ports
//   iCLK        system clock, at least 16x SCL
//   iRST_N      asynchronous active-low reset
//   iI2C_SCLK   SCL from the bus master
//   ioI2C_SDAT  SDA; this block only ever drives 1'b0 or releases it
//   iRD_ADDR    register read-port index
//   oRD_DATA    registered contents of regs[iRD_ADDR] (0 if out of range)
//   oWR_STROBE  one-cycle pulse per committed register write
//   oWR_ADDR    register address of the last committed write
//   oWR_DATA    data of the last committed write
//   oBUSY       high from a START until the following STOP
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iI2C_SCLK,
  inout  logic       ioI2C_SDAT,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oWR_STROBE,
  output logic [6:0] oWR_ADDR,
  output logic [8:0] oWR_DATA,
  output logic       oBUSY
);

  localparam logic [7:0] DEV_WR = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {
    IDLE, DEV, ACK_DEV, REG, ACK_REG, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t      r_state, w_next;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]  r_cnt;
  logic [6:0]  r_shift;
  logic [6:0]  r_reg_addr;
  logic        r_d8;
  logic        r_ack_on;
  logic [8:0]  r_regs [NUM_REGS];

  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic        w_last_bit, w_in_shift, w_in_ack, w_addr_ok, w_commit;
  logic [7:0]  w_byte;
  logic [8:0]  w_wdata;

  // Open-drain: the ACK flag resets asynchronously, so SDA is released
  // as soon as iRST_N falls.
  assign ioI2C_SDAT = r_ack_on ? 1'b0 : 1'bz;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SCL must be high in both samples so an SCL edge racing an SDA
  // change is never taken as a bus condition.
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_last_bit = w_scl_rise & (r_cnt == 3'd7);
  assign w_in_shift = (r_state == DEV) | (r_state == REG) | (r_state == DATA);
  assign w_in_ack   = (r_state == ACK_DEV) | (r_state == ACK_REG) | (r_state == ACK_DATA);
  assign w_addr_ok  = ({25'd0, r_reg_addr} < NUM_REGS);
  assign w_wdata    = {r_d8, w_byte};
  assign w_commit   = (r_state == DATA) & w_last_bit & ~w_start & ~w_stop & w_addr_ok;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = IDLE;
    end else if (w_start) begin
      w_next = DEV;
    end else begin
      case (r_state)
        DEV:      if (w_last_bit) w_next = (w_byte == DEV_WR) ? ACK_DEV : IGNORE;
        REG:      if (w_last_bit) w_next = ACK_REG;
        DATA:     if (w_last_bit) w_next = ACK_DATA;
        ACK_DEV:  if (w_scl_fall && r_ack_on) w_next = REG;
        ACK_REG:  if (w_scl_fall && r_ack_on) w_next = DATA;
        ACK_DATA: if (w_scl_fall && r_ack_on) w_next = IGNORE;
        default:  w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      // Bus-idle reset level avoids a false START when reset releases.
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_reg_addr <= '0;
      r_d8       <= 1'b0;
      r_ack_on   <= 1'b0;
      oBUSY      <= 1'b0;
      oWR_STROBE <= 1'b0;
      oWR_ADDR   <= '0;
      oWR_DATA   <= '0;
      oRD_DATA   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_scl_s1 <= iI2C_SCLK;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= ioI2C_SDAT;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;

      if (w_start) r_cnt <= '0;
      else if (w_scl_rise && w_in_shift) r_cnt <= r_cnt + 3'd1;

      if (w_scl_rise && w_in_shift) r_shift <= w_byte[6:0];

      if ((r_state == REG) && w_last_bit) begin
        r_reg_addr <= w_byte[7:1];
        r_d8       <= w_byte[0];
      end

      // First SCL fall in an ACK state starts driving, the second ends it.
      if (w_start || w_stop || !w_in_ack) r_ack_on <= 1'b0;
      else if (w_scl_fall)                r_ack_on <= ~r_ack_on;

      if (w_start)     oBUSY <= 1'b1;
      else if (w_stop) oBUSY <= 1'b0;

      oWR_STROBE <= w_commit;
      if (w_commit) begin
        oWR_ADDR                <= r_reg_addr;
        oWR_DATA                <= w_wdata;
        r_regs[r_reg_addr[3:0]] <= w_wdata;
      end

      // Forward a same-cycle commit so the read port never lags a write.
      if (w_commit && (r_reg_addr == {3'd0, iRD_ADDR}))
        oRD_DATA <= w_wdata;
      else if ({28'd0, iRD_ADDR} < NUM_REGS)
        oRD_DATA <= r_regs[iRD_ADDR];
      else
        oRD_DATA <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
module tb_i2c_codec_target;

  localparam int Q = 10;  // iCLK cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [3:0] rd_addr = '0;
  wire        sda;
  logic [8:0] rd_data;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_codec_target #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iI2C_SCLK(scl), .ioI2C_SDAT(sda),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data), .oWR_STROBE(wr_strobe),
    .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oBUSY(busy)
  );

  int         strobe_cnt = 0;
  int         dut_low_cnt = 0;
  logic [8:0] fwd_data = '0;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      fwd_data   <= rd_data;
    end
    if (!m_low && sda === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] m_regs [16];
  logic [7:0] t_b [4];
  int         t_n;
  bit         t_stop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    scl = 1'b0; wq(Q);
    m_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    m_low = 1'b1; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    scl = 1'b0; m_low = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    m_low = 1'b0; wq(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; wq(Q);
      scl = 1'b1; wq(2 * Q);
      scl = 1'b0; wq(Q);
    end
  endtask

  task automatic ack_slot(output logic ack);
    m_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    ack = (sda === 1'b0);
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("%s/reg%0d", name, i), 32'(rd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic set_txn(input logic [7:0] b0, b1, b2, b3, input int n, input bit stop);
    t_b[0] = b0; t_b[1] = b1; t_b[2] = b2; t_b[3] = b3; t_n = n; t_stop = stop;
  endtask

  // Reference: the address byte must be 8'h34; the first three bytes are
  // ACKed; a complete 3-byte write to an index below 16 updates that register.
  task automatic run_txn(input string name);
    int         s0, l0;
    logic       ack;
    logic [6:0] ra;
    logic [8:0] wd;
    bit         wr;
    s0 = strobe_cnt;
    l0 = dut_low_cnt;
    ra = t_b[1][7:1];
    wd = {t_b[1][0], t_b[2]};
    wr = (t_n >= 3) && (t_b[0] == 8'h34) && (ra < 7'd16);
    rd_addr = ra[3:0];
    i2c_start();
    chk({name, "/busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < t_n; k++) begin
      send_bits(t_b[k]);
      ack_slot(ack);
      chk($sformatf("%s/ack%0d", name, k), 32'(ack), 32'((t_b[0] == 8'h34) && (k < 3)));
    end
    if (t_stop) begin
      i2c_stop();
      chk({name, "/idle"}, 32'(busy), 32'd0);
    end
    chk({name, "/strobes"}, 32'(strobe_cnt - s0), 32'(wr));
    if (wr) begin
      m_regs[ra[3:0]] = wd;
      chk({name, "/wr_addr"}, 32'(wr_addr), 32'(ra));
      chk({name, "/wr_data"}, 32'(wr_data), 32'(wd));
      chk({name, "/fwd"}, 32'(fwd_data), 32'(wd));
    end
    if (t_b[0] != 8'h34) chk({name, "/sda_quiet"}, 32'(dut_low_cnt - l0), 32'd0);
    check_regs(name);
  endtask

  initial begin
    logic ack;
    int   s0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    wq(3);
    chk("rst/strobe", 32'(wr_strobe), 32'd0);
    chk("rst/wr_addr", 32'(wr_addr), 32'd0);
    chk("rst/wr_data", 32'(wr_data), 32'd0);
    chk("rst/rd_data", 32'(rd_data), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/sda", 32'(sda === 1'b1), 32'd1);
    rst_n = 1'b1;
    wq(Q);

    set_txn(8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1); run_txn("r09");
    set_txn(8'h34, 8'h08, 8'hD2, 8'h00, 3, 1'b1); run_txn("r4lo");
    set_txn(8'h34, 8'h09, 8'hD2, 8'h00, 3, 1'b1); run_txn("r4hi");
    set_txn(8'h36, 8'h12, 8'h01, 8'h00, 3, 1'b1); run_txn("badaddr");
    set_txn(8'h34, 8'h12, 8'h00, 8'h00, 2, 1'b1); run_txn("stop_abort");
    set_txn(8'h34, 8'h0E, 8'h02, 8'h00, 3, 1'b1); run_txn("r7");
    set_txn(8'h34, 8'h05, 8'h00, 8'h00, 2, 1'b0); run_txn("rs_abort");
    set_txn(8'h34, 8'h0E, 8'h03, 8'h00, 3, 1'b1); run_txn("rs_r7");
    set_txn(8'h34, 8'h20, 8'h55, 8'hAA, 4, 1'b1); run_txn("oor");

    // Reset while the REG-byte ACK is being driven.
    s0 = strobe_cnt;
    i2c_start();
    send_bits(8'h34);
    ack_slot(ack);
    chk("mid/ack_dev", 32'(ack), 32'd1);
    send_bits(8'h12);
    m_low = 1'b0;
    wq(2);
    chk("mid/ack_held", 32'(sda === 1'b0), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid/sda_release", 32'(sda === 1'b1), 32'd1);
    chk("mid/busy", 32'(busy), 32'd0);
    chk("mid/wr_addr", 32'(wr_addr), 32'd0);
    chk("mid/wr_data", 32'(wr_data), 32'd0);
    wq(3);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    wq(Q);
    check_regs("mid");
    i2c_stop();
    chk("mid/no_partial", 32'(strobe_cnt - s0), 32'd0);
    set_txn(8'h34, 8'h12, 8'h01, 8'h00, 3, 1'b1); run_txn("post_rst");

    for (int r = 0; r < 24; r++) begin
      int a;
      a = $urandom_range(0, 19);
      t_b[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      t_b[1] = {7'(a), 1'($urandom)};
      t_b[2] = 8'($urandom);
      t_b[3] = 8'($urandom);
      t_n    = $urandom_range(1, 4);
      t_stop = (r == 23) || ($urandom_range(0, 3) != 0);
      run_txn($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
